// File: rtl/image_pkg.sv
// Shared types and constants for the image pipeline window stages.
package image_pkg;

  typedef enum logic {
    s_fill,
    s_active
  } t_win_state;

  localparam int c_win_size = 9;

  // Tap k occupies bits [k*p_width +: p_width] of a window; nw is the oldest pixel, se the newest.
  localparam int c_tap_nw = 8;
  localparam int c_tap_n  = 7;
  localparam int c_tap_ne = 6;
  localparam int c_tap_w  = 5;
  localparam int c_tap_c  = 4;
  localparam int c_tap_e  = 3;
  localparam int c_tap_sw = 2;
  localparam int c_tap_s  = 1;
  localparam int c_tap_se = 0;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single address, write-enabled, reads return the pre-write contents.
module line_buffer #(
  parameter int p_width = 8,
  parameter int p_depth = 640,
  parameter int p_aw    = $clog2(p_depth)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [p_aw-1:0]    i_addr,
  input  logic [p_width-1:0] i_wdata,
  output logic [p_width-1:0] o_rdata
);

  logic [p_width-1:0] r_mem [p_depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3.sv
// Sliding 3x3 neighbourhood generator: buffers two lines and emits one window per interior pixel.
module window_3x3
  import image_pkg::*;
#(
  parameter int p_width = 8,
  parameter int p_cols  = 640,
  parameter int p_rows  = 480
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [p_width-1:0]            i_data_in,
  input  logic                          i_valid_in,
  output logic                          o_ready_in,
  output logic [c_win_size*p_width-1:0] o_window,
  output logic                          o_valid_out,
  input  logic                          i_ready_out,
  output logic                          o_last
);

  localparam int c_cw = $clog2(p_cols);
  localparam int c_rw = $clog2(p_rows);
  localparam logic [c_cw-1:0] c_col_last = c_cw'(p_cols - 1);
  localparam logic [c_rw-1:0] c_row_last = c_rw'(p_rows - 1);
  localparam logic [c_cw-1:0] c_col_first_win = c_cw'(2);
  localparam logic [c_rw-1:0] c_row_fill_done = c_rw'(1);

  logic [c_cw-1:0]                 r_col;
  logic [c_rw-1:0]                 r_row;
  t_win_state                      r_state;
  logic [3*p_width-1:0]            r_col_a;
  logic [3*p_width-1:0]            r_col_b;
  logic                            r_valid;
  logic                            r_last;
  logic [c_win_size*p_width-1:0]   r_window;

  logic                            w_accept;
  logic                            w_col_end;
  logic                            w_frame_end;
  logic                            w_produce;
  logic [p_width-1:0]              w_lb1;
  logic [p_width-1:0]              w_lb2;
  logic [c_win_size*p_width-1:0]   w_window;

  assign o_ready_in  = !r_valid | i_ready_out;
  assign w_accept    = i_valid_in & o_ready_in;
  assign w_col_end   = (r_col == c_col_last);
  assign w_frame_end = w_col_end & (r_row == c_row_last);
  assign w_produce   = w_accept & (r_state == s_active) & (r_col >= c_col_first_win);

  line_buffer #(.p_width(p_width), .p_depth(p_cols)) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (i_data_in),
    .o_rdata (w_lb1)
  );

  line_buffer #(.p_width(p_width), .p_depth(p_cols)) u_lb2 (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb1),
    .o_rdata (w_lb2)
  );

  // Column registers hold {line r-2, line r-1, line r}; the newest column comes straight from the buffers.
  always_comb begin
    w_window = '0;
    w_window[c_tap_nw*p_width +: p_width] = r_col_a[2*p_width +: p_width];
    w_window[c_tap_n *p_width +: p_width] = r_col_b[2*p_width +: p_width];
    w_window[c_tap_ne*p_width +: p_width] = w_lb2;
    w_window[c_tap_w *p_width +: p_width] = r_col_a[p_width +: p_width];
    w_window[c_tap_c *p_width +: p_width] = r_col_b[p_width +: p_width];
    w_window[c_tap_e *p_width +: p_width] = w_lb1;
    w_window[c_tap_sw*p_width +: p_width] = r_col_a[0 +: p_width];
    w_window[c_tap_s *p_width +: p_width] = r_col_b[0 +: p_width];
    w_window[c_tap_se*p_width +: p_width] = i_data_in;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_state  <= s_fill;
      r_col_a  <= '0;
      r_col_b  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_window <= '0;
    end else begin
      if (w_accept) begin
        r_col   <= w_col_end ? '0 : r_col + 1'b1;
        r_col_a <= r_col_b;
        r_col_b <= {w_lb2, w_lb1, i_data_in};
        if (w_col_end) r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        case (r_state)
          s_fill:   if (w_col_end && r_row == c_row_fill_done) r_state <= s_active;
          s_active: if (w_frame_end) r_state <= s_fill;
          default:  r_state <= s_fill;
        endcase
      end
      // A fresh window reloads the output register even while the previous one is being taken.
      if (w_produce) begin
        r_valid  <= 1'b1;
        r_window <= w_window;
        r_last   <= w_frame_end;
      end else if (i_ready_out) begin
        r_valid  <= 1'b0;
        r_window <= '0;
        r_last   <= 1'b0;
      end
    end
  end

  assign o_valid_out = r_valid;
  assign o_window    = r_window;
  assign o_last      = r_last;

endmodule

// File: tb/tb_window_3x3.sv
// Self-checking bench for window_3x3 on a 4x4 image with pixel value row*16 + col.
module tb_window_3x3;

  localparam int c_w  = 8;
  localparam int c_c  = 4;
  localparam int c_r  = 4;
  localparam int c_ww = 9 * c_w;

  logic            i_clk       = 1'b0;
  logic            i_reset_n   = 1'b0;
  logic [c_w-1:0]  i_data_in   = '0;
  logic            i_valid_in  = 1'b0;
  logic            i_ready_out = 1'b1;
  logic            o_ready_in;
  logic [c_ww-1:0] o_window;
  logic            o_valid_out;
  logic            o_last;

  window_3x3 #(.p_width(c_w), .p_cols(c_c), .p_rows(c_r)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_data_in   (i_data_in),
    .i_valid_in  (i_valid_in),
    .o_ready_in  (o_ready_in),
    .o_window    (o_window),
    .o_valid_out (o_valid_out),
    .i_ready_out (i_ready_out),
    .o_last      (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [c_w-1:0]  din;
    logic            expValid;
    logic            expLast;
    logic [c_ww-1:0] expWin;
  } vec_t;

  typedef struct {
    logic [c_ww-1:0] win;
    logic            last;
  } exp_t;

  vec_t            vecs[16];
  logic [c_ww-1:0] refWins[4];
  int              checks = 0;
  int              passes = 0;

  logic [c_w-1:0]  img[c_r][c_c];
  int              modelIdx = 0;
  exp_t            expQ[$];
  logic [c_ww-1:0] obsQ[$];
  logic            obsLast[$];

  task automatic checkOutput(input string name, input logic [c_ww-1:0] act, input logic [c_ww-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [c_w-1:0] pix(input int i);
    return c_w'((((i % 16) / 4) * 16) + (i % 4));
  endfunction

  // Reference window built straight from the stored image, oldest pixel ending up in the MSBs.
  function automatic logic [c_ww-1:0] buildWindow(input int r, input int c);
    logic [c_ww-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w = {w[c_ww-c_w-1:0], img[r-2+dr][c-2+dc]};
    return w;
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    int r, c;
    if (!i_reset_n) begin
      modelIdx = 0;
      expQ.delete();
    end else begin
      if (o_valid_out && i_ready_out) begin
        obsQ.push_back(o_window);
        obsLast.push_back(o_last);
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected window: got %h, expected none", o_window);
        end else begin
          e = expQ.pop_front();
          checkOutput("model window", o_window, e.win);
          checkOutput("model last", {71'b0, o_last}, {71'b0, e.last});
        end
      end
      if (i_valid_in && o_ready_in) begin
        r = modelIdx / c_c;
        c = modelIdx % c_c;
        img[r][c] = i_data_in;
        if (r >= 2 && c >= 2) begin
          e.win  = buildWindow(r, c);
          e.last = (r == c_r - 1) && (c == c_c - 1);
          expQ.push_back(e);
        end
        modelIdx = (modelIdx + 1) % (c_r * c_c);
      end
    end
  end

  // Offers one pixel, optionally after random idle cycles, and waits (bounded) until it is taken.
  task automatic applyStimulus(input logic [c_w-1:0] d, input bit sparse, input bit randReady);
    bit acc;
    int guard;
    guard = 0;
    if (sparse) begin
      while ($urandom_range(1) == 0 && guard < 20) begin
        i_valid_in = 1'b0;
        if (randReady) i_ready_out = 1'($urandom_range(1));
        @(posedge i_clk); #1;
        guard++;
      end
    end
    i_valid_in = 1'b1;
    i_data_in  = d;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 200) begin
      if (randReady) i_ready_out = 1'($urandom_range(1));
      @(negedge i_clk);
      acc = o_ready_in;
      @(posedge i_clk); #1;
      guard++;
    end
    if (!acc) begin
      checks++;
      $display("[TB] FAIL accept timeout: pixel %h not taken, expected accept within 200 cycles", d);
    end
    i_valid_in = 1'b0;
  endtask

  task automatic drain();
    i_valid_in  = 1'b0;
    i_ready_out = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_valid_in = 1'b0;
    i_reset_n  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic checkFrame(input int base, input string name);
    for (int k = 0; k < 4; k++) begin
      if (base + k < obsQ.size()) begin
        checkOutput({name, " window"}, obsQ[base+k], refWins[k]);
        checkOutput({name, " last"}, {71'b0, obsLast[base+k]}, {71'b0, (k == 3)});
      end else begin
        checks++;
        $display("[TB] FAIL %s missing window %0d: got %0d windows, expected %0d", name, k, obsQ.size(), base + 4);
      end
    end
  endtask

  task automatic sendFrame(input int n, input bit sparse, input bit randReady);
    for (int i = 0; i < n; i++) applyStimulus(pix(i), sparse, randReady);
  endtask

  initial begin
    refWins[0] = 72'h00_01_02_10_11_12_20_21_22;
    refWins[1] = 72'h01_02_03_11_12_13_21_22_23;
    refWins[2] = 72'h10_11_12_20_21_22_30_31_32;
    refWins[3] = 72'h11_12_13_21_22_23_31_32_33;
    for (int i = 0; i < 16; i++) begin
      vecs[i].din      = pix(i);
      vecs[i].expValid = 1'b0;
      vecs[i].expLast  = 1'b0;
      vecs[i].expWin   = '0;
    end
    vecs[10] = '{8'h22, 1'b1, 1'b0, 72'h00_01_02_10_11_12_20_21_22};
    vecs[11] = '{8'h23, 1'b1, 1'b0, 72'h01_02_03_11_12_13_21_22_23};
    vecs[14] = '{8'h32, 1'b1, 1'b0, 72'h10_11_12_20_21_22_30_31_32};
    vecs[15] = '{8'h33, 1'b1, 1'b1, 72'h11_12_13_21_22_23_31_32_33};

    $display("[TB] reset");
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset ready_in", {71'b0, o_ready_in}, 72'd1);
    checkOutput("reset valid_out", {71'b0, o_valid_out}, 72'd0);
    checkOutput("reset last", {71'b0, o_last}, 72'd0);
    checkOutput("reset window", o_window, 72'd0);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] full-rate frame from vector table");
    obsQ.delete(); obsLast.delete();
    i_ready_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_data_in  = vecs[i].din;
      i_valid_in = 1'b1;
      @(posedge i_clk); #1;
      checkOutput($sformatf("table valid px%h", vecs[i].din), {71'b0, o_valid_out}, {71'b0, vecs[i].expValid});
      checkOutput($sformatf("table ready px%h", vecs[i].din), {71'b0, o_ready_in}, 72'd1);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("table window px%h", vecs[i].din), o_window, vecs[i].expWin);
        checkOutput($sformatf("table last px%h", vecs[i].din), {71'b0, o_last}, {71'b0, vecs[i].expLast});
      end
    end
    drain();
    checkOutput("full-rate count", 72'(obsQ.size()), 72'd4);
    checkOutput("idle valid_out", {71'b0, o_valid_out}, 72'd0);

    $display("[TB] backpressure");
    obsQ.delete(); obsLast.delete();
    for (int i = 0; i <= 10; i++) applyStimulus(pix(i), 1'b0, 1'b0);
    i_ready_out = 1'b0;
    i_valid_in  = 1'b1;
    i_data_in   = pix(11);
    repeat (5) begin
      @(negedge i_clk);
      checkOutput("stall window", o_window, refWins[0]);
      checkOutput("stall ready_in", {71'b0, o_ready_in}, 72'd0);
      checkOutput("stall valid_out", {71'b0, o_valid_out}, 72'd1);
    end
    @(posedge i_clk); #1;
    i_ready_out = 1'b1;
    for (int i = 11; i < 16; i++) applyStimulus(pix(i), 1'b0, 1'b0);
    drain();
    checkOutput("backpressure count", 72'(obsQ.size()), 72'd4);
    checkFrame(0, "backpressure");

    $display("[TB] sparse input");
    obsQ.delete(); obsLast.delete();
    sendFrame(16, 1'b1, 1'b0);
    drain();
    checkOutput("sparse count", 72'(obsQ.size()), 72'd4);
    checkFrame(0, "sparse");

    $display("[TB] sparse input with random downstream stalls");
    obsQ.delete(); obsLast.delete();
    sendFrame(16, 1'b1, 1'b1);
    drain();
    checkOutput("random stall count", 72'(obsQ.size()), 72'd4);
    checkFrame(0, "random stall");

    $display("[TB] back-to-back frames");
    obsQ.delete(); obsLast.delete();
    sendFrame(32, 1'b0, 1'b0);
    drain();
    checkOutput("two-frame count", 72'(obsQ.size()), 72'd8);
    checkFrame(0, "frame1");
    checkFrame(4, "frame2");

    $display("[TB] mid-frame reset");
    sendFrame(10, 1'b0, 1'b0);
    doReset();
    checkOutput("post-reset valid_out", {71'b0, o_valid_out}, 72'd0);
    checkOutput("post-reset ready_in", {71'b0, o_ready_in}, 72'd1);
    obsQ.delete(); obsLast.delete();
    sendFrame(16, 1'b0, 1'b0);
    drain();
    checkOutput("after-reset count", 72'(obsQ.size()), 72'd4);
    checkFrame(0, "after reset");
    checkOutput("leftover expected", 72'(expQ.size()), 72'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
